// File: rtl/microp_irq_pkg.sv
// Shared constants for the microp interrupt controller: register word
// addresses, the "no source" ID and the largest supported source count.
package microp_irq_pkg;

    localparam logic [2:0] IRQ_PENDING  = 3'd0;
    localparam logic [2:0] IRQ_MASK     = 3'd1;
    localparam logic [2:0] IRQ_EDGE_SEL = 3'd2;
    localparam logic [2:0] IRQ_ACTIVE   = 3'd3;
    localparam logic [2:0] IRQ_ACK      = 3'd4;
    localparam logic [2:0] IRQ_RAW      = 3'd5;

    localparam logic [3:0] IRQ_ID_NONE  = 4'hF;
    localparam int         NUM_IRQ_MAX  = 15;
    localparam int         DATA_W       = 16;

endpackage

// File: rtl/microp_irq_prio_enc.sv
// Combinational priority encoder: lowest set index wins.
// id is IRQ_ID_NONE and valid is 0 when no request is set.
module microp_irq_prio_enc
    import microp_irq_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [3:0]         id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        id    = IRQ_ID_NONE;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = 4'(i);
            end
        end
    end

endmodule

// File: rtl/microp_irq_ctrl.sv
// Interrupt controller: latches edge/level sources, masks them, resolves
// priority and presents a registered irq_out/irq_id to the CPU. Registers
// are reached over a 16-bit Avalon-MM slave.
//
// Bus timing: there is no wait-request. A write is accepted on any clock
// edge where chipselect=1 and write_n=0. readdata is re-registered from
// the address mux on every clock edge, so the value for a read presented
// at edge k is visible after edge k+1 (fixed one-cycle latency).
module microp_irq_ctrl
    import microp_irq_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               chipselect,
    input  logic [2:0]         address,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out,
    output logic [3:0]         irq_id
);

    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] edge_sel_q, edge_sel_d;
    logic [NUM_IRQ-1:0] irq_d_q, irq_d_d;
    logic               irq_out_q, irq_out_d;
    logic [3:0]         irq_id_q, irq_id_d;
    logic [15:0]        readdata_q, readdata_d;

    logic               wr;
    logic               wr_pending, wr_mask, wr_edge_sel, wr_ack;
    logic [NUM_IRQ-1:0] wdata_n;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] mode_chg;
    logic [NUM_IRQ-1:0] active;
    logic               enc_valid;
    logic [3:0]         enc_id;
    logic               act_valid;
    logic               unused_wdata;

    // Write strobes per register.
    assign wr          = chipselect & ~write_n;
    assign wr_pending  = wr && (address == IRQ_PENDING);
    assign wr_mask     = wr && (address == IRQ_MASK);
    assign wr_edge_sel = wr && (address == IRQ_EDGE_SEL);
    assign wr_ack      = wr && (address == IRQ_ACK);
    assign wdata_n     = writedata[NUM_IRQ-1:0];
    assign unused_wdata = ^writedata;

    assign rise   = irq_in & ~irq_d_q;
    assign active = pending_q & mask_q;

    // Pending update: edge sources set on rise (set beats clear), level
    // sources track the input; any bit whose mode is being rewritten drops.
    always_comb begin
        clr      = '0;
        mode_chg = '0;
        if (wr_pending) begin
            clr = wdata_n;
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (wr_ack && (writedata[3:0] == 4'(i))) begin
                clr[i] = 1'b1;
            end
        end
        if (wr_edge_sel) begin
            mode_chg = edge_sel_q ^ wdata_n;
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (edge_sel_q[i]) begin
                pending_d[i] = rise[i] | (pending_q[i] & ~clr[i]);
            end else begin
                pending_d[i] = irq_in[i];
            end
        end
        pending_d = pending_d & ~mode_chg;
    end

    // Control registers and the input delay line.
    always_comb begin
        mask_d     = wr_mask ? wdata_n : mask_q;
        edge_sel_d = wr_edge_sel ? wdata_n : edge_sel_q;
        irq_d_d    = irq_in;
    end

    microp_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .req   (active),
        .valid (enc_valid),
        .id    (enc_id)
    );

    // Registered CPU-facing request and winning ID.
    always_comb begin
        irq_out_d = enc_valid;
        irq_id_d  = enc_id;
    end

    assign act_valid = (irq_id_q != IRQ_ID_NONE);

    // Read mux, registered every clock regardless of chipselect.
    always_comb begin
        readdata_d = 16'h0000;
        case (address)
            IRQ_PENDING:  readdata_d = 16'(pending_q);
            IRQ_MASK:     readdata_d = 16'(mask_q);
            IRQ_EDGE_SEL: readdata_d = 16'(edge_sel_q);
            IRQ_ACTIVE:   readdata_d = {act_valid, 11'b0, irq_id_q};
            IRQ_RAW:      readdata_d = 16'(irq_in);
            default:      readdata_d = 16'h0000;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            mask_q     <= '0;
            edge_sel_q <= '0;
            irq_d_q    <= '0;
            irq_out_q  <= 1'b0;
            irq_id_q   <= IRQ_ID_NONE;
            readdata_q <= 16'h0000;
        end else begin
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            edge_sel_q <= edge_sel_d;
            irq_d_q    <= irq_d_d;
            irq_out_q  <= irq_out_d;
            irq_id_q   <= irq_id_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq_out  = irq_out_q;
    assign irq_id   = irq_id_q;

endmodule

// File: tb/tb_microp_irq_ctrl.sv
// Directed bench for microp_irq_ctrl. Drivers push expected values into
// queues; a monitor on the falling edge pops and compares whenever a read
// result or an irq check is due.
module tb_microp_irq_ctrl;
    import microp_irq_pkg::*;

    localparam int NUM_IRQ = 8;
    localparam int W       = 16;

    logic               clk        = 1'b0;
    logic               reset_n    = 1'b0;
    logic               chipselect = 1'b0;
    logic [2:0]         address    = 3'd0;
    logic               write_n    = 1'b1;
    logic [15:0]        writedata  = 16'h0000;
    logic [15:0]        readdata;
    logic [NUM_IRQ-1:0] irq_in     = '0;
    logic               irq_out;
    logic [3:0]         irq_id;

    microp_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq_out    (irq_out),
        .irq_id     (irq_id)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    string        rd_name_q[$];
    logic [4:0]   irq_q[$];
    string        irq_name_q[$];
    int           vectors     = 0;
    int           miscompares = 0;
    logic         rd_v;
    logic         irq_chk = 1'b0;

    // A read issued at edge k has its data after edge k+1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_v <= 1'b0;
        else          rd_v <= chipselect & write_n;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [4:0]   ei;
        string        nm;
        if (rd_v) begin
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_read: readdata=%h, no expected value queued", readdata);
            end else begin
                e  = exp_q.pop_front();
                nm = rd_name_q.pop_front();
                vectors++;
                if (readdata !== e) begin
                    miscompares++;
                    $display("FAIL %s: readdata=%h expected=%h", nm, readdata, e);
                end
            end
        end
        if (irq_chk) begin
            if (irq_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_irq_check: no expected value queued");
            end else begin
                ei = irq_q.pop_front();
                nm = irq_name_q.pop_front();
                vectors++;
                if ({irq_out, irq_id} !== ei) begin
                    miscompares++;
                    $display("FAIL %s: irq_out=%b irq_id=%h expected irq_out=%b irq_id=%h",
                             nm, irq_out, irq_id, ei[4], ei[3:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [15:0] e, input string nm);
        @(posedge clk); #1;
        chipselect = 1'b1; write_n = 1'b1; address = a;
        exp_q.push_back(e);
        rd_name_q.push_back(nm);
        @(posedge clk); #1;
        chipselect = 1'b0;
    endtask

    task automatic check_irq(input logic o, input logic [3:0] id, input string nm);
        @(posedge clk); #1;
        irq_q.push_back({o, id});
        irq_name_q.push_back(nm);
        irq_chk = 1'b1;
        @(negedge clk); #1;
        irq_chk = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: stimulus did not complete within time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(1);

        // 1: reset values. ACTIVE carries the none ID 0xF with valid=0.
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), (3'(a) == IRQ_ACTIVE) ? 16'h000F : 16'h0000, $sformatf("t1_read_addr%0d", a));
        end
        check_irq(1'b0, 4'hF, "t1_irq_reset");

        // 2: single edge source with a one-cycle pulse.
        bus_write(IRQ_MASK, 16'h0001);
        bus_write(IRQ_EDGE_SEL, 16'h0001);
        irq_in[0] = 1'b1;
        check_irq(1'b0, 4'hF, "t2_irq_same_edge_as_pend");
        irq_in[0] = 1'b0;
        check_irq(1'b1, 4'h0, "t2_irq_next_edge");
        bus_read(IRQ_PENDING, 16'h0001, "t2_pending");
        bus_read(IRQ_ACTIVE, 16'h8000, "t2_active");
        bus_write(IRQ_PENDING, 16'h0001);
        check_irq(1'b0, 4'hF, "t2_irq_after_w1c");

        // 3: level sources and priority.
        bus_write(IRQ_EDGE_SEL, 16'h0000);
        bus_write(IRQ_MASK, 16'h00FF);
        irq_in = 8'h24;
        step(2);
        check_irq(1'b1, 4'h2, "t3_irq_id2");
        bus_read(IRQ_ACTIVE, 16'h8002, "t3_active");
        bus_read(IRQ_PENDING, 16'h0024, "t3_pending");
        bus_read(IRQ_RAW, 16'h0024, "t3_raw");
        irq_in = 8'h20;
        step(2);
        check_irq(1'b1, 4'h5, "t3_irq_id5");
        irq_in = 8'h00;
        step(2);
        check_irq(1'b0, 4'hF, "t3_irq_none");
        irq_in = 8'h08;
        step(2);
        bus_write(IRQ_PENDING, 16'h0008);
        bus_read(IRQ_PENDING, 16'h0008, "t3_level_ignores_w1c");
        irq_in = 8'h00;
        step(2);

        // 4: set beats ACK, out-of-range ACK ignored.
        bus_write(IRQ_EDGE_SEL, 16'h00FF);
        irq_in = 8'h0A;
        step(1);
        irq_in = 8'h00;
        bus_read(IRQ_PENDING, 16'h000A, "t4_pending_pulse");
        check_irq(1'b1, 4'h1, "t4_irq_id1");
        @(posedge clk); #1;
        chipselect = 1'b1; write_n = 1'b0; address = IRQ_ACK; writedata = 16'd3;
        irq_in[3] = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        irq_in[3] = 1'b0;
        bus_read(IRQ_PENDING, 16'h000A, "t4_set_beats_ack");
        bus_write(IRQ_ACK, 16'd9);
        bus_read(IRQ_PENDING, 16'h000A, "t4_ack_out_of_range");
        bus_write(IRQ_ACK, 16'd3);
        bus_read(IRQ_PENDING, 16'h0002, "t4_ack3");
        bus_write(IRQ_PENDING, 16'h0002);
        bus_read(IRQ_PENDING, 16'h0000, "t4_w1c1");

        // 5: held-high edge source pends once; mode change clears.
        irq_in[1] = 1'b1;
        step(2);
        bus_read(IRQ_PENDING, 16'h0002, "t5_pend_held");
        bus_write(IRQ_PENDING, 16'h0002);
        step(3);
        bus_read(IRQ_PENDING, 16'h0000, "t5_no_repend");
        irq_in[1] = 1'b0;
        step(2);
        irq_in[1] = 1'b1;
        step(2);
        bus_read(IRQ_PENDING, 16'h0002, "t5_repend_after_fall_rise");
        bus_write(IRQ_EDGE_SEL, 16'h00EF);
        irq_in[4] = 1'b1;
        step(2);
        bus_read(IRQ_PENDING, 16'h0012, "t5_level_bit4");
        bus_write(IRQ_EDGE_SEL, 16'h00FF);
        bus_read(IRQ_PENDING, 16'h0002, "t5_mode_change_clears");
        check_irq(1'b1, 4'h1, "t5_irq_id1");

        // 6: asynchronous reset in mid-cycle.
        @(posedge clk); #1;
        reset_n = 1'b0;
        irq_q.push_back({1'b0, 4'hF});
        irq_name_q.push_back("t6_irq_async_reset");
        irq_chk = 1'b1;
        @(negedge clk); #1;
        irq_chk = 1'b0;
        step(2);
        reset_n = 1'b1;
        bus_read(IRQ_MASK, 16'h0000, "t6_mask_after_reset");
        bus_read(IRQ_EDGE_SEL, 16'h0000, "t6_edge_sel_after_reset");
        bus_read(IRQ_PENDING, 16'h0012, "t6_level_pending_after_reset");
        check_irq(1'b0, 4'hF, "t6_irq_masked_after_reset");
        irq_in = 8'h00;

        step(3);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL read_queue_drain: %0d left, expected 0", exp_q.size());
        end
        if (irq_q.size() != 0) begin
            miscompares++;
            $display("FAIL irq_queue_drain: %0d left, expected 0", irq_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
